// File: rtl/alu_pkg.sv
// alu_pkg: shared funct encodings and FSM state type for the sequential mul/div unit.
//   FN_*    : 5-bit ALU funct codes handled by alu_muldiv_seq
//   state_t : controller states (IDLE, MUL, DIV, DONE)
package alu_pkg;

    localparam logic [4:0] FN_MFHI = 5'b00011;
    localparam logic [4:0] FN_MFLO = 5'b00100;
    localparam logic [4:0] FN_MUL  = 5'b00101;
    localparam logic [4:0] FN_DIV  = 5'b00110;
    localparam logic [4:0] FN_DIVU = 5'b00111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: iterative shift-add multiplier / restoring divider datapath on operand magnitudes.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture operand magnitudes, signs and mode; clear accumulator
//   step            : advance one iteration
//   is_div          : 1 = divide, 0 = multiply (sampled on load)
//   is_signed       : treat operands as two's complement (sampled on load)
//   a_in, b_in      : operand A (multiplicand / dividend), operand B (multiplier / divisor)
//   hi_out, lo_out  : sign-corrected result as it will stand after the current step
//                     (mul: product high/low word; div: remainder / quotient)
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0]     acc_hi, nxt_hi, sum, shl;
    logic [XLEN-1:0]   acc_lo, nxt_lo, opnd, mag_a, mag_b;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic              div_mode, neg_q, neg_r, sa, sb, ge;

    always_comb begin
        sa       = is_signed & a_in[XLEN-1];
        sb       = is_signed & b_in[XLEN-1];
        mag_a    = sa ? -a_in : a_in;
        mag_b    = sb ? -b_in : b_in;
        // multiply: add multiplicand when the multiplier LSB is set, then shift {hi,lo} right
        sum      = acc_hi + {1'b0, opnd & {XLEN{acc_lo[0]}}};
        // divide: shift the next dividend bit into the partial remainder, subtract if it fits
        shl      = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
        ge       = shl >= {1'b0, opnd};
        nxt_hi   = div_mode ? (ge ? shl - {1'b0, opnd} : shl) : {1'b0, sum[XLEN:1]};
        nxt_lo   = div_mode ? {acc_lo[XLEN-2:0], ge} : {sum[0], acc_lo[XLEN-1:1]};
        prod     = {nxt_hi[XLEN-1:0], nxt_lo};
        prod_fix = neg_q ? -prod : prod;
        hi_out   = div_mode ? (neg_r ? -nxt_hi[XLEN-1:0] : nxt_hi[XLEN-1:0]) : prod_fix[2*XLEN-1:XLEN];
        lo_out   = div_mode ? (neg_q ? -nxt_lo : nxt_lo) : prod_fix[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (load) begin
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            opnd     <= mag_b;
            div_mode <= is_div;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
        end else if (step) begin
            acc_hi   <= nxt_hi;
            acc_lo   <= nxt_lo;
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequential mul/div/divu unit with architectural HI/LO and mfhi/mflo readback.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request strobe, accepted only while busy is low
//   funct      : 5-bit operation code (alu_pkg FN_*)
//   a_input    : operand A (multiplicand / dividend)
//   b_input    : operand B (multiplier / divisor)
//   busy       : operation in flight (MUL or DIV)
//   done       : one-cycle completion pulse
//   res        : result word, held until overwritten by a later operation
//   hi, lo     : architectural HI/LO registers
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      funct,
    input  logic [XLEN-1:0] a_input,
    input  logic [XLEN-1:0] b_input,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    state_t          state, state_nxt, issue_st;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] core_hi, core_lo;
    logic            accept, last, is_div_op, div_zero;

    assign accept    = start & ~busy;
    assign last      = cnt == CW'(ITERS - 1);
    assign is_div_op = (funct == FN_DIV) || (funct == FN_DIVU);
    assign div_zero  = is_div_op && (b_input == '0);
    // divide-by-zero, moves and unsupported codes complete in a single cycle
    assign issue_st  = (funct == FN_MUL) ? MUL : (is_div_op && !div_zero) ? DIV : DONE;

    muldiv_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (busy),
        .is_div    (is_div_op),
        .is_signed (funct != FN_DIVU),
        .a_in      (a_input),
        .b_in      (b_input),
        .hi_out    (core_hi),
        .lo_out    (core_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = busy ? (last ? DONE : state) : (accept ? issue_st : IDLE);
    end

    always_comb begin
        busy = (state == MUL) || (state == DIV);
        done = state == DONE;
    end

    // the final iteration and the HI/LO write share one edge: capture the core's post-step view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            res <= '0;
            hi  <= '0;
            lo  <= '0;
        end else if (accept) begin
            cnt <= '0;
            case (funct)
                FN_MFHI: res <= hi;
                FN_MFLO: res <= lo;
                FN_MUL:  ;
                FN_DIV, FN_DIVU: begin
                    if (div_zero) begin
                        res <= '1;
                        lo  <= '1;
                        hi  <= a_input;
                    end
                end
                default: res <= '0;
            endcase
        end else if (busy) begin
            cnt <= cnt + CW'(1);
            if (last) begin
                hi  <= core_hi;
                lo  <= core_lo;
                res <= core_lo;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: randomized and directed checks of alu_muldiv_seq against an arithmetic reference model.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  funct = '0;
    logic [31:0] a_input = '0, b_input = '0;
    logic        busy, done;
    logic [31:0] res, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;

    alu_muldiv_seq #(.XLEN(XLEN), .ITERS(ITERS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct   (funct),
        .a_input (a_input),
        .b_input (b_input),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference: plain signed/unsigned 64-bit arithmetic; returns the expected busy length
    task automatic model(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b, output int lat);
        longint sa, sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 0;
        if (fn == FN_MFHI) m_res = m_hi;
        else if (fn == FN_MFLO) m_res = m_lo;
        else if (fn == FN_MUL) begin
            p = 64'(sa * sb);
            m_hi = p[63:32]; m_lo = p[31:0]; m_res = m_lo; lat = ITERS;
        end else if ((fn == FN_DIV || fn == FN_DIVU) && b == 0) begin
            m_hi = a; m_lo = '1; m_res = '1;
        end else if (fn == FN_DIV) begin
            m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); m_res = m_lo; lat = ITERS;
        end else if (fn == FN_DIVU) begin
            m_lo = a / b; m_hi = a % b; m_res = m_lo; lat = ITERS;
        end else m_res = '0;
    endtask

    task automatic wait_done(input string tag, input int k0, input int lat);
        int k;
        k = k0;
        while (!done && k < ITERS + 8) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".lat"}, 64'(k), 64'(lat));
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
        chk({tag, ".res"}, res, m_res);
    endtask

    // call with busy low; inputs are scrambled after acceptance to prove they were latched
    task automatic run_op(input string tag, input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        model(fn, a, b, lat);
        funct = fn; a_input = a; b_input = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_input = $urandom; b_input = $urandom; funct = 5'($urandom);
        if (lat > 0) chk({tag, ".busy"}, 64'(busy), 64'd1);
        wait_done(tag, 0, lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = '0;
            1: pick = '1;
            2: pick = MIN;
            3: pick = 32'd1;
            4: pick = 32'($urandom_range(0, 20));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        bit saw_done;
        logic [4:0] fn;
        #1 rst_n = 1'b0;
        #7;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.res", res, 64'd0);
        chk("rst.hilo", {hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("mul7x-3", FN_MUL, 32'd7, -32'sd3);
        run_op("div-7/2", FN_DIV, -32'sd7, 32'd2);
        run_op("mflo", FN_MFLO, 32'd0, 32'd0);
        run_op("mfhi", FN_MFHI, 32'd0, 32'd0);
        run_op("divu", FN_DIVU, 32'hFFFF_FFFF, 32'd16);
        run_op("divmin", FN_DIV, MIN, 32'hFFFF_FFFF);
        run_op("div0", FN_DIV, 32'd5, 32'd0);
        run_op("divu0", FN_DIVU, 32'hDEAD_BEEF, 32'd0);
        run_op("bad", 5'b01010, 32'd1, 32'd2);
        @(posedge clk); #1;
        chk("done.drop", 64'(done), 64'd0);
        chk("idle.busy", 64'(busy), 64'd0);

        // start re-pulsed mid-flight must be ignored; new mul in DONE cycle must be taken
        model(FN_MUL, 32'd3, 32'd4, lat);
        funct = FN_MUL; a_input = 32'd3; b_input = 32'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 a_input = 32'd9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("repulse", 5, ITERS);
        run_op("b2b", FN_MUL, 32'd5, 32'd6);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: fn = FN_MFHI;
                1: fn = FN_MFLO;
                2, 3, 4: fn = FN_MUL;
                5, 6: fn = FN_DIV;
                7, 8: fn = FN_DIVU;
                default: fn = 5'($urandom_range(8, 31));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            run_op("rand", fn, pick(), pick());
        end

        // asynchronous reset in the middle of a divide
        funct = FN_DIV; a_input = 32'd100; b_input = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        chk("arst.res", res, 64'd0);
        chk("arst.hilo", {hi, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (ITERS + 4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("arst.nodone", 64'(saw_done), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        m_hi = '0; m_lo = '0; m_res = '0;
        run_op("arst.mfhi", FN_MFHI, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
